// File: rtl/decode_pkg.sv
// RV32I ID-stage shared types: opcode map, ALU one-hot bit indices, field encodings, reset bundle.
// Pure declarations; no timing or backpressure of its own.
package decode_pkg;

    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_B     = 7'd99;
    localparam logic [6:0] OP_S     = 7'd35;
    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_AUIPC = 7'd23;
    localparam logic [6:0] OP_JALR  = 7'd103;
    localparam logic [6:0] OP_JAL   = 7'd111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;

    localparam int ALU_W_BASE = 10;
    localparam int ALU_W_M    = 18;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_BR  = 3'b010;
    localparam logic [2:0] IMM_U   = 3'b011;
    localparam logic [2:0] IMM_J   = 3'b100;
    localparam logic [2:0] IMM_ISH = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    localparam logic [2:0] SEL_NONE   = 3'b111;
    localparam logic [2:0] BR_DEFAULT = 3'b010;

    typedef struct packed {
        logic [1:0] jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       reg_write;
        logic       mem_write;
        logic       illegal;
        logic [2:0] imm_sel;
        logic [2:0] bropcode;
        logic [2:0] store_sel;
        logic [2:0] load_sel;
        logic [1:0] write_back;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{
        jump: JMP_NONE, branch: 1'b0, alu_src_a: 1'b0, alu_src_b: 1'b0,
        reg_write: 1'b0, mem_write: 1'b0, illegal: 1'b0, imm_sel: IMM_I,
        bropcode: BR_DEFAULT, store_sel: SEL_NONE, load_sel: SEL_NONE,
        write_back: WB_ALU, rd: 5'd0, rs1: 5'd0, rs2: 5'd0
    };

    // alt selects the funct7=0100000 variant (sub / sra) where one exists
    function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
        logic [4:0] idx;
        case (funct3)
            3'b000:  idx = alt ? ALU_SUB : ALU_ADD;
            3'b001:  idx = ALU_SLL;
            3'b010:  idx = ALU_SLT;
            3'b011:  idx = ALU_SLTU;
            3'b100:  idx = ALU_XOR;
            3'b101:  idx = alt ? ALU_SRA : ALU_SRL;
            3'b110:  idx = ALU_OR;
            default: idx = ALU_AND;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I instruction-to-control decode with illegal and source-use flags; RV32M_EN adds M ops.
// Zero latency, no state; backpressure is handled entirely by the enclosing pipe register.
module decode_comb
    import decode_pkg::*;
#(
    parameter int ALU_CTRL_W = ALU_W_BASE
) (
    input  logic [31:0]           instr_i,
    output ctrl_t                 ctrl_o,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic                  use_rs1_o,
    output logic                  use_rs2_o
`ifdef RV32M_EN
    ,
    output logic                  is_div_o
`endif
);

    localparam logic [ALU_CTRL_W-1:0] ALU_ONE = {{(ALU_CTRL_W-1){1'b0}}, 1'b1};

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] alu_idx;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        ctrl_o     = CTRL_RST;
        ctrl_o.rd  = instr_i[11:7];
        ctrl_o.rs1 = instr_i[19:15];
        ctrl_o.rs2 = instr_i[24:20];
        alu_idx    = ALU_ADD;
        use_rs1_o  = 1'b0;
        use_rs2_o  = 1'b0;
`ifdef RV32M_EN
        is_div_o   = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.imm_sel   = IMM_BR;
                use_rs1_o        = 1'b1;
                use_rs2_o        = 1'b1;
                if (funct7 == F7_BASE || funct7 == F7_ALT)
                    alu_idx = alu_base(funct3, funct7 == F7_ALT);
`ifdef RV32M_EN
                else if (funct7 == F7_MULDIV) begin
                    alu_idx  = ALU_MUL + {2'b00, funct3};
                    is_div_o = funct3[2];
                end
`endif
                else
                    ctrl_o.illegal = 1'b1;
            end
            OP_I: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                use_rs1_o        = 1'b1;
                // funct7 only matters for the shift-immediates
                alu_idx = alu_base(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                if (funct3 == 3'b001) begin
                    ctrl_o.imm_sel = IMM_ISH;
                    ctrl_o.illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    ctrl_o.imm_sel = IMM_ISH;
                    ctrl_o.illegal = !(funct7 == F7_BASE || funct7 == F7_ALT);
                end
            end
            OP_B: begin
                ctrl_o.branch     = 1'b1;
                ctrl_o.imm_sel    = IMM_BR;
                ctrl_o.write_back = WB_MEM;
                ctrl_o.bropcode   = (funct3 == 3'b010 || funct3 == 3'b011) ? BR_DEFAULT : funct3;
                use_rs1_o         = 1'b1;
                use_rs2_o         = 1'b1;
            end
            OP_S: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.imm_sel    = IMM_S;
                ctrl_o.store_sel  = funct3;
                ctrl_o.write_back = WB_MEM;
                use_rs1_o         = 1'b1;
                use_rs2_o         = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.load_sel   = funct3;
                ctrl_o.write_back = WB_MEM;
                use_rs1_o         = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.imm_sel    = IMM_U;
                ctrl_o.write_back = WB_IMM;
            end
            OP_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.imm_sel   = IMM_U;
            end
            OP_JALR: begin
                ctrl_o.jump       = JMP_JALR;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.write_back = WB_PC4;
                use_rs1_o         = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.jump       = JMP_JAL;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.imm_sel    = IMM_J;
                ctrl_o.write_back = WB_PC4;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
        if (ctrl_o.illegal) begin
            ctrl_o.reg_write = 1'b0;
            ctrl_o.mem_write = 1'b0;
            ctrl_o.branch    = 1'b0;
            ctrl_o.jump      = JMP_NONE;
        end
        alu_ctrl_o = ALU_ONE << alu_idx;
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32I decode stage with load-use interlock and illegal counter; RV32M_EN adds M decode + divide busy.
// Latency 1 cycle; in_ready drops on full-and-stalled, load-use hazard or divide busy; held bundle is stable under stall.
module decode_ctrl_pipe
    import decode_pkg::*;
#(
`ifdef RV32M_EN
    parameter int ALU_CTRL_W = ALU_W_M,
`else
    parameter int ALU_CTRL_W = ALU_W_BASE,
`endif
    parameter int DIV_CYCLES = 32,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            jump,
    output logic                  branch,
    output logic                  alu_srcA,
    output logic                  alu_srcB,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  illegal,
    output logic [2:0]            imm_sel,
    output logic [2:0]            bropcode,
    output logic [2:0]            store_sel,
    output logic [2:0]            load_sel,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [1:0]            write_back,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [ILL_CNT_W-1:0]  ill_cnt
);

`ifdef RV32M_EN
    localparam int ALU_W_MIN = ALU_W_M;
`else
    localparam int ALU_W_MIN = ALU_W_BASE;
`endif
    localparam logic [ALU_CTRL_W-1:0] ALU_RST = {{(ALU_CTRL_W-1){1'b0}}, 1'b1};
    localparam logic [ILL_CNT_W-1:0]  ILL_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

    if (ALU_CTRL_W < ALU_W_MIN) begin : g_bad_alu_w
        $error("decode_ctrl_pipe: ALU_CTRL_W too small");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_div_cycles
        $error("decode_ctrl_pipe: DIV_CYCLES out of range 1..255");
    end

    ctrl_t                 dec;
    logic [ALU_CTRL_W-1:0] dec_alu;
    logic                  dec_use_rs1, dec_use_rs2;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [ALU_CTRL_W-1:0] alu_q, alu_d;
    logic                  out_valid_q, out_valid_d;
    logic [ILL_CNT_W-1:0]  ill_q, ill_d;
    logic                  busy, hazard, accept;
`ifdef RV32M_EN
    logic                  dec_is_div;
    logic [7:0]            busy_q, busy_d;
`endif

    decode_comb #(.ALU_CTRL_W(ALU_CTRL_W)) u_decode_comb (
        .instr_i    (instr),
        .ctrl_o     (dec),
        .alu_ctrl_o (dec_alu),
        .use_rs1_o  (dec_use_rs1),
        .use_rs2_o  (dec_use_rs2)
`ifdef RV32M_EN
        ,
        .is_div_o   (dec_is_div)
`endif
    );

    // a held load's data is not forwardable yet, so a consumer of its rd waits a cycle
    assign hazard = out_valid_q && (ctrl_q.load_sel != SEL_NONE) && (ctrl_q.rd != 5'd0)
                 && ((dec_use_rs1 && (dec.rs1 == ctrl_q.rd)) || (dec_use_rs2 && (dec.rs2 == ctrl_q.rd)));
    assign in_ready = !busy && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        alu_d       = alu_q;
        ill_d       = ill_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec;
            alu_d       = dec_alu;
            if (dec.illegal && (ill_q != {ILL_CNT_W{1'b1}}))
                ill_d = ill_q + ILL_ONE;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_RST;
            alu_q       <= ALU_RST;
            ill_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            alu_q       <= alu_d;
            ill_q       <= ill_d;
        end
    end

`ifdef RV32M_EN
    assign busy = (busy_q != 8'd0);

    always_comb begin
        busy_d = busy_q;
        if (flush)
            busy_d = 8'd0;
        else if (accept && dec_is_div)
            busy_d = 8'(DIV_CYCLES - 1);
        else if (busy)
            busy_d = busy_q - 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= 8'd0;
        else     busy_q <= busy_d;
    end
`else
    assign busy = 1'b0;
`endif

    assign out_valid  = out_valid_q;
    assign jump       = ctrl_q.jump;
    assign branch     = ctrl_q.branch;
    assign alu_srcA   = ctrl_q.alu_src_a;
    assign alu_srcB   = ctrl_q.alu_src_b;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_write  = ctrl_q.mem_write;
    assign illegal    = ctrl_q.illegal;
    assign imm_sel    = ctrl_q.imm_sel;
    assign bropcode   = ctrl_q.bropcode;
    assign store_sel  = ctrl_q.store_sel;
    assign load_sel   = ctrl_q.load_sel;
    assign alu_ctrl   = alu_q;
    assign write_back = ctrl_q.write_back;
    assign rd         = ctrl_q.rd;
    assign rs1        = ctrl_q.rs1;
    assign rs2        = ctrl_q.rs2;
    assign ill_cnt    = ill_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: directed test-plan steps then random traffic against a spec-level model.
module tb_decode_ctrl_pipe;

`ifdef RV32M_EN
    localparam int ALU_W = 18;
    localparam bit M_EN  = 1'b1;
`else
    localparam int ALU_W = 10;
    localparam bit M_EN  = 1'b0;
`endif
    localparam int DIV_CYCLES = 4;
    localparam int ILL_MAX    = 255;

    logic             clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      instr;
    logic [1:0]       jump, write_back;
    logic             branch, alu_srcA, alu_srcB, reg_write, mem_write, illegal;
    logic [2:0]       imm_sel, bropcode, store_sel, load_sel;
    logic [ALU_W-1:0] alu_ctrl;
    logic [4:0]       rd, rs1, rs2;
    logic [7:0]       ill_cnt;

    decode_ctrl_pipe #(.ALU_CTRL_W(ALU_W), .DIV_CYCLES(DIV_CYCLES), .ILL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .jump(jump),
        .branch(branch), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .reg_write(reg_write),
        .mem_write(mem_write), .illegal(illegal), .imm_sel(imm_sel), .bropcode(bropcode),
        .store_sel(store_sel), .load_sel(load_sel), .alu_ctrl(alu_ctrl),
        .write_back(write_back), .rd(rd), .rs1(rs1), .rs2(rs2), .ill_cnt(ill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state: what the stage should be holding
    bit          m_valid;
    logic [31:0] m_held;
    int          m_ill;
    int          m_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return op == 7'd51 || op == 7'd19 || op == 7'd99 || op == 7'd35 || op == 7'd3 ||
               op == 7'd55 || op == 7'd23 || op == 7'd103 || op == 7'd111;
    endfunction

    function automatic bit m_illegal(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        if (!known_op(op)) return 1'b1;
        if (op == 7'd51) return !(f7 == 7'h00 || f7 == 7'h20 || (M_EN && f7 == 7'h01));
        if (op == 7'd19 && f3 == 3'd1) return f7 != 7'h00;
        if (op == 7'd19 && f3 == 3'd5) return !(f7 == 7'h00 || f7 == 7'h20);
        return 1'b0;
    endfunction

    function automatic bit uses_rs1(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        return op == 7'd51 || op == 7'd99 || op == 7'd35 || op == 7'd19 || op == 7'd3 || op == 7'd103;
    endfunction

    function automatic bit uses_rs2(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        return op == 7'd51 || op == 7'd99 || op == 7'd35;
    endfunction

    function automatic bit is_div(input logic [31:0] w);
        return M_EN && w[6:0] == 7'd51 && w[31:25] == 7'h01 && w[14];
    endfunction

    function automatic logic [ALU_W-1:0] exp_alu(input logic [31:0] w);
        logic [6:0]       op = w[6:0];
        logic [2:0]       f3 = w[14:12];
        logic [6:0]       f7 = w[31:25];
        logic [ALU_W-1:0] one = 1;
        int               bitno;
        // funct3 -> add sll slt sltu xor srl or and
        case (f3)
            3'd0: bitno = 0; 3'd1: bitno = 2; 3'd2: bitno = 3; 3'd3: bitno = 4;
            3'd4: bitno = 5; 3'd5: bitno = 6; 3'd6: bitno = 8; default: bitno = 9;
        endcase
        if (op == 7'd51) begin
            if (m_illegal(w)) bitno = 0;
            else if (f7 == 7'h01) bitno = 10 + int'(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) bitno = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) bitno = 7;
        end else if (op == 7'd19) begin
            if (f3 == 3'd5 && f7 == 7'h20) bitno = 7;
        end else begin
            bitno = 0;
        end
        return one << bitno;
    endfunction

    function automatic logic [41:0] exp_bundle(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [1:0] j, wb;
        logic       br, sa, sb, rw, mw, il;
        logic [2:0] imm, bro, st, ld;
        j = 2'd0; wb = 2'd0; br = 0; sa = 0; sb = 0; rw = 0; mw = 0;
        imm = 3'd0; bro = 3'd2; st = 3'd7; ld = 3'd7;
        case (op)
            7'd51:  begin rw = 1; imm = 3'd2; end
            7'd19:  begin rw = 1; sb = 1; imm = (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0; end
            7'd99:  begin br = 1; imm = 3'd2; wb = 2'd1; bro = (f3 == 3'd2 || f3 == 3'd3) ? 3'd2 : f3; end
            7'd35:  begin mw = 1; sb = 1; imm = 3'd1; st = f3; wb = 2'd1; end
            7'd3:   begin rw = 1; sb = 1; ld = f3; wb = 2'd1; end
            7'd55:  begin rw = 1; imm = 3'd3; wb = 2'd3; end
            7'd23:  begin rw = 1; sa = 1; sb = 1; imm = 3'd3; end
            7'd103: begin j = 2'd2; rw = 1; wb = 2'd2; end
            7'd111: begin j = 2'd1; rw = 1; imm = 3'd4; wb = 2'd2; end
            default: ;
        endcase
        il = m_illegal(w);
        if (il) begin rw = 0; mw = 0; br = 0; j = 2'd0; end
        return {j, br, sa, sb, rw, mw, il, imm, bro, st, ld, wb, w[11:7], w[19:15], w[24:20]};
    endfunction

    function automatic logic [41:0] obs_bundle();
        return {jump, branch, alu_srcA, alu_srcB, reg_write, mem_write, illegal, imm_sel,
                bropcode, store_sel, load_sel, write_back, rd, rs1, rs2};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 12);
        case (k)
            0: w[6:0] = 7'd51;  1: w[6:0] = 7'd19;  2: w[6:0] = 7'd99;  3: w[6:0] = 7'd35;
            4: w[6:0] = 7'd3;   5: w[6:0] = 7'd3;   6: w[6:0] = 7'd55;  7: w[6:0] = 7'd23;
            8: w[6:0] = 7'd103; 9: w[6:0] = 7'd111; 10: w[6:0] = 7'h7F;
            default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    // drive one cycle, check in_ready before the edge and the registered state after it
    task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl,
                        output logic rdy_obs);
        bit hz, rdy, acc;
        in_valid = v; instr = w; out_ready = ordy; flush = fl;
        #2;
        hz = m_valid && m_held[6:0] == 7'd3 && m_held[14:12] != 3'd7 && m_held[11:7] != 5'd0 &&
             ((uses_rs1(w) && w[19:15] == m_held[11:7]) || (uses_rs2(w) && w[24:20] == m_held[11:7]));
        rdy = (m_busy == 0) && !hz && (!m_valid || ordy);
        rdy_obs = in_ready;
        chk("in_ready", in_ready, rdy);
        acc = v && rdy;
        if (fl) begin
            m_valid = 0;
            m_busy  = 0;
        end else if (acc) begin
            m_valid = 1;
            m_held  = w;
            if (m_illegal(w) && m_ill < ILL_MAX) m_ill++;
            if (is_div(w)) m_busy = DIV_CYCLES - 1;
        end else begin
            if (ordy) m_valid = 0;
            if (m_busy > 0) m_busy--;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("ill_cnt", ill_cnt, m_ill);
        if (m_valid) begin
            chk("bundle", obs_bundle(), exp_bundle(m_held));
            chk("alu_ctrl", alu_ctrl, exp_alu(m_held));
        end
    endtask

    task automatic check_reset_state(input string tag);
        logic [41:0] rst_bundle = {2'b00, 6'b000000, 3'b000, 3'b010, 3'b111, 3'b111, 2'b00, 15'd0};
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_ill_cnt"}, ill_cnt, 0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 1);
        chk({tag, "_bundle"}, obs_bundle(), rst_bundle);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic r;
        int   lows;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; instr = '0;
        m_valid = 0; m_held = '0; m_ill = 0; m_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 0;

        // add x3,x1,x2
        step(1, 32'h002081B3, 1, 0, r);
        chk("add_in_ready", r, 1);
        chk("add_out_valid", out_valid, 1);
        chk("add_alu", alu_ctrl, 1);
        chk("add_reg_write", reg_write, 1);
        chk("add_rd", rd, 3);
        chk("add_imm_sel", imm_sel, 3'b010);

        // lw x5,0(x1) then add x6,x5,x2: one stall, one bubble
        step(1, 32'h0000A283, 1, 0, r);
        step(1, 32'h00228333, 1, 0, r);
        chk("luse_stall", r, 0);
        chk("luse_bubble", out_valid, 0);
        step(1, 32'h00228333, 1, 0, r);
        chk("luse_issue", r, 1);
        chk("luse_rd", rd, 6);

        // lw x0,0(x1) then add x6,x0,x2: rd=x0 never stalls
        step(1, 32'h0000A003, 1, 0, r);
        step(1, 32'h00200333, 1, 0, r);
        chk("x0_no_stall", r, 1);

        // addi x7,x0,5 held under 4 cycles of backpressure
        step(1, 32'h00500393, 1, 0, r);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h00208433, 0, 0, r);
            chk("bp_in_ready", r, 0);
            chk("bp_rd_stable", rd, 7);
        end
        step(1, 32'h00208433, 1, 0, r);
        chk("bp_release", r, 1);
        chk("bp_next_rd", rd, 8);

        // flush with both held and incoming valid; incoming illegal word must not count
        step(1, 32'h002081B3, 1, 0, r);
        step(1, 32'hFFFFFFFF, 1, 1, r);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_ill_cnt", ill_cnt, 0);

        // 300 illegal opcodes saturate the 8-bit counter
        for (int i = 0; i < 300; i++) begin
            step(1, {25'($urandom), 7'h7F}, 1, 0, r);
            chk("ill_flag", illegal, 1);
            chk("ill_reg_write", reg_write, 0);
        end
        chk("ill_saturated", ill_cnt, 255);

        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0), r);

        // asynchronous reset during a load-use stall
        step(1, 32'h0000A283, 1, 0, r);
        in_valid = 1; instr = 32'h00228333; out_ready = 1;
        #2;
        chk("mid_stall_in_ready", in_ready, 0);
        rst = 1;
        #1;
        check_reset_state("mid_reset");
        m_valid = 0; m_ill = 0; m_busy = 0;
        @(posedge clk);
        #1;
        rst = 0;

`ifdef RV32M_EN
        // div x1,x2,x3 blocks issue for DIV_CYCLES-1 cycles
        step(1, 32'h023140B3, 1, 0, r);
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h002081B3, 1, 0, r);
            if (!r) lows++;
        end
        chk("div_busy_cycles", lows, DIV_CYCLES - 1);
        step(1, 32'h023140B3, 1, 0, r);
        step(1, 32'h002081B3, 1, 1, r);
        chk("div_flush_busy", r, 0);
        step(1, 32'h002081B3, 1, 0, r);
        chk("div_flush_ready", r, 1);
        step(1, 32'h023140B3, 1, 0, r);
        step(1, 32'h002081B3, 1, 0, r);
        in_valid = 1; instr = 32'h002081B3; out_ready = 1;
        rst = 1;
        #1;
        check_reset_state("mid_div_reset");
        m_valid = 0; m_ill = 0; m_busy = 0;
        @(posedge clk);
        #1;
        rst = 0;
`else
        lows = 0;
`endif
        for (int i = 0; i < 20; i++)
            step(1, rand_instr(), 1, 0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
